onchip_mem_arbiter: RTL and testbench

- Shares the single-port on-chip RAM (32-bit, 10240 words, 14-bit word address, byte enables, fixed read latency) between two Avalon-MM masters.
- Typical masters: Nios II data port on m0 and a DMA/peripheral master on m1.
- Arbitrates per cycle with round-robin fairness and honours Avalon `lock` for atomic sequences.
- Converts the RAM's fixed read latency into per-master `readdatavalid` pulses.

---
 rtl/onchip_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port on-chip RAM with fixed read latency.
// Round-robin per cycle, Avalon lock support, and per-master readdatavalid generation.
module onchip_mem_arbiter #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BE_W       = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic [1:0] {
    StUnlocked,
    StLocked0,
    StLocked1
  } lock_e;

  lock_e lock_q, lock_d;
  logic  last_q, last_d;
  logic  req0, req1;
  logic  grant0, grant1;
  logic  rd_accept;

  logic [RD_LATENCY-1:0] pipe_valid_q;
  logic [RD_LATENCY-1:0] pipe_owner_q;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Grant: lock owner is exclusive; otherwise a tie goes to the master not granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case (lock_q)
      StLocked0: grant0 = req0;
      StLocked1: grant1 = req1;
      default: begin
        if (req0 && req1) begin
          grant0 = last_q;
          grant1 = ~last_q;
        end else begin
          grant0 = req0;
          grant1 = req1;
        end
      end
    endcase
  end

  // While locked the owner is always granted when requesting, so releasing lock either with
  // a granted transfer or while idle reduces to the owner's lock input going low.
  always_comb begin
    lock_d = lock_q;
    unique case (lock_q)
      StUnlocked: begin
        if (grant0 && m0_lock) begin
          lock_d = StLocked0;
        end else if (grant1 && m1_lock) begin
          lock_d = StLocked1;
        end
      end
      StLocked0: if ((grant0 || !req0) && !m0_lock) lock_d = StUnlocked;
      StLocked1: if ((grant1 || !req1) && !m1_lock) lock_d = StUnlocked;
      default:   lock_d = StUnlocked;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (grant1) begin
      last_d = 1'b1;
    end else if (grant0) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q <= StUnlocked;
      last_q <= 1'b1;
    end else begin
      lock_q <= lock_d;
      last_q <= last_d;
    end
  end

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    if (grant0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_write      = m0_write;
    end else if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end
  end

  assign mem_chipselect = grant0 | grant1;
  assign mem_clken      = 1'b1;

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  // A write with read also asserted is served as a write and returns nothing.
  assign rd_accept = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid_q <= '0;
      pipe_owner_q <= '0;
    end else begin
      pipe_valid_q[0] <= rd_accept;
      pipe_owner_q[0] <= grant1;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_owner_q[i] <= pipe_owner_q[i-1];
      end
    end
  end

  assign m0_readdatavalid = pipe_valid_q[RD_LATENCY-1] & ~pipe_owner_q[RD_LATENCY-1];
  assign m1_readdatavalid = pipe_valid_q[RD_LATENCY-1] &  pipe_owner_q[RD_LATENCY-1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  m0_rw_excl: assert property (@(posedge clk) disable iff (reset) !(m0_read && m0_write));
  m1_rw_excl: assert property (@(posedge clk) disable iff (reset) !(m1_read && m1_write));

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: RAM latency 1 and 2 builds driven in lockstep, checked every
// cycle against a transaction-level model (grant rules, reference memory, return queue).
module tb_onchip_mem_arbiter;
  localparam int unsigned AW    = 14;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = 4;
  localparam int unsigned DEPTH = 10240;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic          lk;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
  } mreq_t;

  typedef struct {
    int            acc;
    int            owner;
    logic [DW-1:0] data;
  } ret_t;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  mreq_t s0 = '0;
  mreq_t s1 = '0;

  logic [1:0]    m0_wait, m1_wait, m0_rvld, m1_rvld, cs, we, clken;
  logic [DW-1:0] m0_rdata [2];
  logic [DW-1:0] m1_rdata [2];
  logic [DW-1:0] mem_wd   [2];
  logic [DW-1:0] mem_rd   [2];
  logic [AW-1:0] mem_a    [2];
  logic [BW-1:0] mem_be   [2];

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            last_w = 1;
  int            lock_own = -1;
  ret_t          rq[$];
  logic [DW-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    if (i == 32) return 32'hAAAAAAAA;
    return DW'(i) * 32'h01000193 + 32'h1234;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [DW-1:0] ram   [DEPTH];
    logic [DW-1:0] rpipe [g+1];

    onchip_mem_arbiter #(.RD_LATENCY(g + 1)) u_dut (
      .clk              (clk),
      .reset            (reset),
      .m0_address       (s0.addr),
      .m0_byteenable    (s0.be),
      .m0_read          (s0.rd),
      .m0_write         (s0.wr),
      .m0_writedata     (s0.wd),
      .m0_lock          (s0.lk),
      .m0_waitrequest   (m0_wait[g]),
      .m0_readdata      (m0_rdata[g]),
      .m0_readdatavalid (m0_rvld[g]),
      .m1_address       (s1.addr),
      .m1_byteenable    (s1.be),
      .m1_read          (s1.rd),
      .m1_write         (s1.wr),
      .m1_writedata     (s1.wd),
      .m1_lock          (s1.lk),
      .m1_waitrequest   (m1_wait[g]),
      .m1_readdata      (m1_rdata[g]),
      .m1_readdatavalid (m1_rvld[g]),
      .mem_address      (mem_a[g]),
      .mem_byteenable   (mem_be[g]),
      .mem_chipselect   (cs[g]),
      .mem_write        (we[g]),
      .mem_writedata    (mem_wd[g]),
      .mem_clken        (clken[g]),
      .mem_readdata     (mem_rd[g])
    );

    initial for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);

    // Fixed-latency RAM: readdata appears g+1 cycles after the address is captured.
    always @(posedge clk) begin
      if (cs[g] && we[g]) ram[mem_a[g]] <= merge(ram[mem_a[g]], mem_wd[g], mem_be[g]);
      rpipe[0] <= ram[mem_a[g]];
      for (int i = 1; i <= g; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rd[g] = rpipe[g];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int exp_grant();
    bit r0 = s0.rd | s0.wr;
    bit r1 = s1.rd | s1.wr;
    if (lock_own == 0) return r0 ? 0 : -1;
    if (lock_own == 1) return r1 ? 1 : -1;
    if (r0 && r1) return (last_w == 0) ? 1 : 0;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic check_outputs(input int g);
    mreq_t w = (g == 1) ? s1 : s0;
    for (int k = 0; k < 2; k++) begin
      string         p  = $sformatf("lat%0d ", k + 1);
      bit            v0 = 1'b0;
      bit            v1 = 1'b0;
      logic [DW-1:0] d  = '0;
      foreach (rq[i]) begin
        if (rq[i].acc + k + 1 == cyc) begin
          v0 = (rq[i].owner == 0);
          v1 = (rq[i].owner == 1);
          d  = rq[i].data;
        end
      end
      check({p, "m0_waitrequest"}, m0_wait[k], (s0.rd | s0.wr) && g != 0);
      check({p, "m1_waitrequest"}, m1_wait[k], (s1.rd | s1.wr) && g != 1);
      check({p, "mem_chipselect"}, cs[k], g >= 0);
      check({p, "mem_write"}, we[k], g >= 0 && w.wr);
      check({p, "mem_address"}, mem_a[k], (g >= 0) ? w.addr : '0);
      check({p, "mem_byteenable"}, mem_be[k], (g >= 0) ? w.be : '0);
      check({p, "mem_writedata"}, mem_wd[k], (g >= 0) ? w.wd : '0);
      check({p, "mem_clken"}, clken[k], 1'b1);
      check({p, "m0_readdatavalid"}, m0_rvld[k], v0);
      check({p, "m1_readdatavalid"}, m1_rvld[k], v1);
      if (v0) check({p, "m0_readdata"}, m0_rdata[k], d);
      if (v1) check({p, "m1_readdata"}, m1_rdata[k], d);
    end
  endtask

  task automatic update_model(input int g);
    mreq_t w = (g == 1) ? s1 : s0;
    mreq_t o = (lock_own == 1) ? s1 : s0;
    if (g >= 0) begin
      if (w.wr) ref_mem[w.addr] = merge(ref_mem[w.addr], w.wd, w.be);
      else rq.push_back('{acc: cyc, owner: g, data: ref_mem[w.addr]});
      last_w = g;
    end
    if (lock_own < 0) begin
      if (g >= 0 && w.lk) lock_own = g;
    end else if ((g == lock_own || !(o.rd | o.wr)) && !o.lk) begin
      lock_own = -1;
    end
    while (rq.size() > 0 && rq[0].acc + 2 <= cyc) rq.delete(0);
  endtask

  task automatic run_cycle(input mreq_t a, input mreq_t b, output int g);
    s0 = a;
    s1 = b;
    @(negedge clk);
    g = exp_grant();
    check_outputs(g);
    update_model(g);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    s0 = '0;
    s1 = '0;
    rq.delete();
    last_w = 1;
    lock_own = -1;
    @(negedge clk);
    check_outputs(-1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
  endtask

  function automatic mreq_t mk(input bit rd, input bit wr, input bit lk, input int addr,
                               input logic [BW-1:0] be, input logic [DW-1:0] wd);
    mreq_t r;
    r.rd   = rd;
    r.wr   = wr;
    r.lk   = lk;
    r.addr = AW'(addr);
    r.be   = be;
    r.wd   = wd;
    return r;
  endfunction

  function automatic mreq_t rand_req(input bit both_read);
    mreq_t r;
    int    k = $urandom_range(0, 9);
    r.rd   = both_read ? 1'b1 : (k < 4);
    r.wr   = both_read ? 1'b0 : (k >= 4 && k < 7);
    r.lk   = both_read ? 1'b0 : ($urandom_range(0, 3) == 0);
    r.addr = ($urandom_range(0, 15) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 7));
    r.be   = BW'($urandom);
    r.wd   = $urandom;
    return r;
  endfunction

  // Masters keep their request stable while the model says they are being held off.
  task automatic run_traffic(input int n, input bit both_read);
    mreq_t a = '0;
    mreq_t b = '0;
    bit    hold0 = 1'b0;
    bit    hold1 = 1'b0;
    int    g;
    for (int i = 0; i < n; i++) begin
      if (!hold0) a = rand_req(both_read);
      if (!hold1) b = rand_req(both_read);
      run_cycle(a, b, g);
      hold0 = (a.rd | a.wr) && g != 0;
      hold1 = (b.rd | b.wr) && g != 1;
    end
  endtask

  initial begin
    int    g;
    mreq_t idle = '0;
    mreq_t m1rd;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

    apply_reset();
    for (int i = 0; i < 3; i++) run_cycle(idle, idle, g);

    // Single read of a preloaded word.
    run_cycle(mk(1, 0, 0, 16, 4'hF, 0), idle, g);
    check("single_read data", m0_rdata[0], 32'hDEADBEEF);
    check("single_read valid", m0_rvld[0], 1'b1);
    check("single_read m1 valid", m1_rvld[0], 1'b0);
    for (int i = 0; i < 2; i++) run_cycle(idle, idle, g);

    // Contention: both masters read every cycle.
    run_traffic(10, 1'b1);
    for (int i = 0; i < 2; i++) run_cycle(idle, idle, g);

    // Partial write then read-back.
    run_cycle(idle, mk(0, 1, 0, 32, 4'b0101, 32'h11223344), g);
    run_cycle(idle, mk(1, 0, 0, 32, 4'hF, 0), g);
    check("byte_merge data", m1_rdata[0], 32'hAA22AA44);
    check("byte_merge valid", m1_rvld[0], 1'b1);
    run_cycle(idle, idle, g);

    // Locked sequence from m0 while m1 requests throughout.
    m1rd = mk(1, 0, 0, 5, 4'hF, 0);
    run_cycle(mk(1, 0, 1, 1, 4'hF, 0), m1rd, g);
    run_cycle(mk(0, 1, 1, 2, 4'h3, 32'hCAFEF00D), m1rd, g);
    run_cycle(mk(1, 0, 0, 2, 4'hF, 0), m1rd, g);
    run_cycle(idle, m1rd, g);
    check("lock m1 granted after", g, 1);

    // Owner idle while locked still blocks the other master.
    run_cycle(mk(1, 0, 1, 3, 4'hF, 0), idle, g);
    run_cycle(mk(0, 0, 1, 0, 4'h0, 0), m1rd, g);
    run_cycle(mk(0, 0, 0, 0, 4'h0, 0), m1rd, g);
    run_cycle(idle, m1rd, g);
    for (int i = 0; i < 2; i++) run_cycle(idle, idle, g);

    // Reset the cycle after m1 is granted a locked read.
    run_cycle(idle, mk(1, 0, 1, 16, 4'hF, 0), g);
    apply_reset();
    run_cycle(mk(1, 0, 0, 4, 4'hF, 0), mk(1, 0, 0, 6, 4'hF, 0), g);
    check("post_reset tie winner", g, 0);
    run_cycle(idle, mk(1, 0, 0, 6, 4'hF, 0), g);
    for (int i = 0; i < 2; i++) run_cycle(idle, idle, g);

    run_traffic(400, 1'b0);
    for (int i = 0; i < 4; i++) run_cycle(idle, idle, g);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
